mux_rr_reg: RTL and testbench

//   Parametrised N-channel, W-bit multiplexer with a registered valid/ready output stage.
//   Two selection modes: fixed select (external sel) or round-robin scan of requesting channels.

---
 rtl/mux_rr_reg_if.sv | 36 +++
 rtl/mux_rr_reg.sv | 82 ++++++++
 tb/tb_mux_rr_reg.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_reg_if.sv
// Streaming bundle between the channel sources, the mux and its sink.
// Sized by channel count and data width; channel index width is derived.
interface mux_rr_reg_if #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH-1:0]        in_valid;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_ready;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel mux with fixed or round-robin selection and a registered
// valid/ready output slot that reports the winning channel index.
module mux_rr_reg #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [$clog2(N_CH)-1:0]  sel,
    mux_rr_reg_if.slave              bus
);
    localparam int SEL_W = $clog2(N_CH);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_g;
    logic             rr_hit;
    logic             fx_hit;
    logic [SEL_W-1:0] g;
    logic             hit;
    logic             free;
    logic             grant;
    logic [SEL_W:0]   idx;

    assign free = !bus.out_valid || bus.out_ready;

    // Scan downward so the channel closest to rr_ptr wins last.
    always_comb begin
        rr_hit = 1'b0;
        rr_g   = '0;
        idx    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
            if (idx >= (SEL_W + 1)'(N_CH))
                idx = idx - (SEL_W + 1)'(N_CH);
            if (bus.in_valid[idx[SEL_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_g   = idx[SEL_W-1:0];
            end
        end
    end

    assign fx_hit = (int'(sel) < N_CH) && bus.in_valid[sel];

    always_comb begin
        hit = 1'b0;
        g   = '0;
        unique case (mode)
            1'b1: begin
                hit = rr_hit;
                g   = rr_g;
            end
            1'b0: begin
                hit = fx_hit;
                g   = sel;
            end
        endcase
    end

    assign grant = rst_n && free && hit;

    assign bus.in_ready = grant
        ? ({{(N_CH-1){1'b0}}, 1'b1} << g)
        : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            rr_ptr        <= '0;
        end else if (free) begin
            bus.out_valid <= grant;
            if (grant) begin
                bus.out_data <= bus.in_data[int'(g)*DATA_W +: DATA_W];
                bus.out_ch   <= g;
            end
            if (grant && mode)
                rr_ptr <= (g == SEL_W'(N_CH - 1)) ? '0 : g + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboarded bench for mux_rr_reg: 8-channel instance driven by a
// behavioural model, plus a 6-channel instance for out-of-range select.
module tb_mux_rr_reg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode8 = 1'b0;
    logic [2:0] sel8 = '0;
    logic       mode6 = 1'b0;
    logic [2:0] sel6 = '0;

    int n_chk = 0;
    int n_err = 0;

    logic [10:0] sb[$];
    logic        m_ov;
    int          m_ptr;

    mux_rr_reg_if #(.N_CH(8), .DATA_W(8)) b8 ();
    mux_rr_reg_if #(.N_CH(6), .DATA_W(8)) b6 ();

    mux_rr_reg #(.N_CH(8), .DATA_W(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode8),
        .sel   (sel8),
        .bus   (b8.slave)
    );

    mux_rr_reg #(.N_CH(6), .DATA_W(8)) u6 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode6),
        .sel   (sel6),
        .bus   (b6.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 8; i++)
            b8.in_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic model_reset();
        m_ov  = 1'b0;
        m_ptr = 0;
        sb.delete();
    endtask

    // One clock of the 8-channel DUT against the model; call away from edges.
    task automatic step();
        bit         fr;
        int         eg;
        logic [7:0] erdy;
        logic [7:0] ed;
        fr = !m_ov || b8.out_ready;
        eg = -1;
        if (fr) begin
            if (!mode8) begin
                if (b8.in_valid[sel8]) eg = int'(sel8);
            end else begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (eg < 0 && b8.in_valid[j]) eg = j;
                end
            end
        end
        erdy = (eg >= 0) ? 8'(1 << eg) : 8'h00;
        ed   = (eg >= 0) ? b8.in_data[eg*8 +: 8] : 8'h00;
        #1;
        chk("in_ready", 32'(b8.in_ready), 32'(erdy));
        @(posedge clk);
        #1;
        if (m_ov && b8.out_ready && sb.size() > 0)
            void'(sb.pop_front());
        if (eg >= 0) begin
            sb.push_back({3'(eg), ed});
            m_ov = 1'b1;
            if (mode8) m_ptr = (eg == 7) ? 0 : eg + 1;
        end else if (fr) begin
            m_ov = 1'b0;
        end
        chk("out_valid", 32'(b8.out_valid), 32'(m_ov));
        if (m_ov) begin
            if (sb.size() > 0) begin
                chk("out_data", 32'(b8.out_data), 32'(sb[0][7:0]));
                chk("out_ch", 32'(b8.out_ch), 32'(sb[0][10:8]));
            end else begin
                chk("sb_empty", 32'(sb.size()), 32'd1);
            end
        end
    endtask

    initial begin
        int exp_seq[6];
        exp_seq = '{0, 2, 7, 0, 2, 7};
        b8.in_valid  = 8'hFF;
        b8.out_ready = 1'b0;
        set_data(8'hA0);
        b6.in_valid  = '0;
        b6.in_data   = '0;
        b6.out_ready = 1'b0;
        model_reset();

        #12;
        chk("rst_out_valid", 32'(b8.out_valid), 32'd0);
        chk("rst_out_data", 32'(b8.out_data), 32'd0);
        chk("rst_out_ch", 32'(b8.out_ch), 32'd0);
        chk("rst_in_ready", 32'(b8.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // fixed select of channel 5
        mode8 = 1'b0;
        sel8 = 3'd5;
        b8.out_ready = 1'b1;
        step();
        chk("fix_data", 32'(b8.out_data), 32'hA5);
        chk("fix_ch", 32'(b8.out_ch), 32'd5);

        // round-robin over channels 0, 2, 7
        mode8 = 1'b1;
        b8.in_valid = 8'b1000_0101;
        set_data(8'h10);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_seq", 32'(b8.out_ch), 32'(exp_seq[i]));
        end

        // back-pressure holds the beat and the pointer
        b8.in_valid = 8'hFF;
        set_data(8'h30);
        step();
        b8.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_ch", 32'(b8.out_ch), 32'd0);
            chk("stall_data", 32'(b8.out_data), 32'h30);
        end
        b8.out_ready = 1'b1;
        step();
        chk("release_ch", 32'(b8.out_ch), 32'd1);

        // wrap from pointer 7 back to 0
        b8.in_valid = 8'h40;
        step();
        b8.in_valid = 8'h80;
        step();
        chk("wrap7", 32'(b8.out_ch), 32'd7);
        b8.in_valid = 8'h81;
        step();
        chk("wrap0", 32'(b8.out_ch), 32'd0);

        // asynchronous reset while a beat is held
        b8.out_ready = 1'b0;
        b8.in_valid = 8'hFF;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(b8.out_valid), 32'd0);
        chk("arst_ready", 32'(b8.in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        b8.out_ready = 1'b1;
        step();
        chk("post_rst_ch", 32'(b8.out_ch), 32'd0);

        // randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            mode8 = 1'($urandom_range(0, 1));
            sel8 = 3'($urandom_range(0, 7));
            b8.in_valid = 8'($urandom);
            b8.out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 8; c++)
                b8.in_data[c*8 +: 8] = 8'($urandom);
            step();
        end

        // six-channel instance with an out-of-range select
        mode6 = 1'b0;
        sel6 = 3'd2;
        b6.in_valid = 6'h3F;
        for (int c = 0; c < 6; c++)
            b6.in_data[c*8 +: 8] = 8'h60 + 8'(c);
        b6.out_ready = 1'b1;
        #1;
        chk("n6_rdy2", 32'(b6.in_ready), 32'h04);
        @(posedge clk);
        #1;
        chk("n6_valid", 32'(b6.out_valid), 32'd1);
        chk("n6_data", 32'(b6.out_data), 32'h62);
        sel6 = 3'd7;
        #1;
        chk("n6_rdy7", 32'(b6.in_ready), 32'h00);
        @(posedge clk);
        #1;
        chk("n6_drop", 32'(b6.out_valid), 32'd0);
        sel6 = 3'd6;
        #1;
        chk("n6_rdy6", 32'(b6.in_ready), 32'h00);
        @(posedge clk);
        #1;
        chk("n6_idle", 32'(b6.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
